// File: rtl/bitty_ctrl_fsm.sv
// Four-phase instruction sequencer for the bitty datapath: accept, load S,
// load C, write back, with a register-immediate format and illegal-format trap.
module bitty_ctrl_fsm #(
  parameter int INSTR_W = 16,
  parameter int REG_AW  = 3,
  parameter int DATA_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     run,
  input  logic [INSTR_W-1:0]       instruction,
  output logic [REG_AW-1:0]        mux_sel,
  output logic                     imm_sel,
  output logic [DATA_W-1:0]        imm,
  output logic [3:0]               alu_sel,
  output logic                     mode,
  output logic                     en_s,
  output logic                     en_c,
  output logic [(2**REG_AW)-1:0]   en_reg,
  output logic                     done,
  output logic                     busy,
  output logic                     illegal
);

  localparam int IMM_W = INSTR_W - REG_AW - 7;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_S = 3'd1,
    LOAD_C = 3'd2,
    WRITE  = 3'd3,
    ERR    = 3'd4
  } state_t;

  state_t               state, state_n;
  logic [INSTR_W-1:0]   instr_q;

  logic [REG_AW-1:0]    f_rx, f_ry;
  logic [3:0]           f_alu;
  logic                 f_mode;
  logic                 f_is_imm;
  logic [IMM_W-1:0]     f_imm;

  always_comb begin
    f_rx     = instr_q[INSTR_W-1 -: REG_AW];
    f_ry     = instr_q[INSTR_W-REG_AW-1 -: REG_AW];
    f_alu    = instr_q[6:3];
    f_mode   = instr_q[2];
    f_is_imm = (instr_q[1:0] == 2'b01);
    f_imm    = instr_q[INSTR_W-REG_AW-1:7];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      instr_q <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && run) instr_q <= instruction;
    end
  end

  // Outputs depend only on state and instr_q, so run/instruction never
  // reach an output combinationally.
  always_comb begin
    state_n = state;
    mux_sel = '0;
    imm_sel = 1'b0;
    imm     = '0;
    alu_sel = '0;
    mode    = 1'b0;
    en_s    = 1'b0;
    en_c    = 1'b0;
    en_reg  = '0;
    done    = 1'b0;
    busy    = 1'b0;
    illegal = 1'b0;
    case (state)
      IDLE: begin
        if (run) state_n = instruction[1] ? ERR : LOAD_S;
      end
      LOAD_S: begin
        mux_sel = f_rx;
        en_s    = 1'b1;
        busy    = 1'b1;
        state_n = LOAD_C;
      end
      LOAD_C, WRITE: begin
        busy    = 1'b1;
        alu_sel = f_alu;
        mode    = f_mode;
        if (f_is_imm) begin
          imm_sel = 1'b1;
          imm     = DATA_W'(f_imm);
        end else begin
          mux_sel = f_ry;
        end
        if (state == LOAD_C) begin
          en_c    = 1'b1;
          state_n = WRITE;
        end else begin
          en_reg[f_rx] = 1'b1;
          done         = 1'b1;
          state_n      = IDLE;
        end
      end
      ERR: begin
        done    = 1'b1;
        illegal = 1'b1;
        busy    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
